// File: rtl/fetch_sequencer.sv
// fetch_sequencer: holds the PC, runs the instruction-memory req/ack handshake,
// presents the fetched word to decode and advances the PC by 4 or to a redirect target.
// Every output is registered or decoded from state, so no input reaches
// imem_req, instr_valid or pc through combinational logic.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,

    // Instruction memory handshake
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,

    // Decode-side view
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,

    // Control unit
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,

    // Status
    output logic        align_err,
    output logic [15:0] issue_count
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StIssue = 2'd2
    } stateT;

    localparam logic [31:0] PcStep   = 32'd4;
    localparam logic [15:0] CountMax = 16'hFFFF;

    stateT       stateQ, stateD;
    logic [31:0] pcQ, pcD;
    logic [31:0] instrQ, instrD;
    logic        alignErrQ, alignErrD;
    logic [15:0] issueCountQ, issueCountD;

    // Helper terms for the issue decision
    logic        issueNow;
    logic [31:0] seqPc;
    logic [31:0] redirPc;
    logic        redirMisaligned;
    logic [15:0] countInc;

    // Issue only happens from ISSUE with stall low; stall overrides redirect.
    always_comb begin
        issueNow        = (stateQ == StIssue) && !stall;
        seqPc           = pcQ + PcStep;
        redirPc         = {redirect_target[31:2], 2'b00};
        redirMisaligned = (redirect_target[1:0] != 2'b00);
        countInc        = (issueCountQ == CountMax) ? issueCountQ : issueCountQ + 16'd1;
    end

    // Next-state logic: state transitions, PC advance, instruction capture, status.
    always_comb begin
        stateD      = stateQ;
        pcD         = pcQ;
        instrD      = instrQ;
        alignErrD   = alignErrQ;
        issueCountD = issueCountQ;

        unique case (stateQ)
            StIdle: begin
                stateD = StFetch;
            end

            StFetch: begin
                if (imem_ack) begin
                    instrD = imem_rdata;
                    stateD = StIssue;
                end
            end

            StIssue: begin
                if (issueNow) begin
                    stateD      = StFetch;
                    issueCountD = countInc;
                    if (redirect) begin
                        pcD = redirPc;
                        // Sticky until reset; the low bits are dropped from the PC.
                        if (redirMisaligned) begin
                            alignErrD = 1'b1;
                        end
                    end else begin
                        pcD = seqPc;
                    end
                end
            end

            default: begin
                stateD = StIdle;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ      <= StIdle;
            pcQ         <= RESET_PC;
            instrQ      <= 32'h0000_0000;
            alignErrQ   <= 1'b0;
            issueCountQ <= 16'h0000;
        end else begin
            stateQ      <= stateD;
            pcQ         <= pcD;
            instrQ      <= instrD;
            alignErrQ   <= alignErrD;
            issueCountQ <= issueCountD;
        end
    end

    // Outputs decoded from state or driven straight from registers; imem_req
    // therefore drops as soon as reset forces the state back to IDLE.
    always_comb begin
        imem_req    = (stateQ == StFetch);
        instr_valid = (stateQ == StIssue);
        imem_addr   = pcQ;
        pc          = pcQ;
        instr       = instrQ;
        align_err   = alignErrQ;
        issue_count = issueCountQ;
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: transaction-level reference (expected PC, instruction,
// issue count and alignment flag per fetch/issue transaction) with randomized
// wait states, stalls, redirects and ignored-input noise.
module tb_fetch_sequencer;

    localparam logic [31:0] ResetPc = 32'h0040_0000;
    localparam logic [31:0] WrapPc  = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = 32'h0;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic        align_err;
    logic [15:0] issue_count;

    logic        wReq;
    logic [31:0] wAddr;
    logic [31:0] wInstr;
    logic        wValid;
    logic [31:0] wPc;
    logic        wAlign;
    logic [15:0] wCount;

    fetch_sequencer #(.RESET_PC(ResetPc)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .instr           (instr),
        .instr_valid     (instr_valid),
        .pc              (pc),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .align_err       (align_err),
        .issue_count     (issue_count)
    );

    // Second instance sharing all inputs, used for the PC wrap-around boundary.
    fetch_sequencer #(.RESET_PC(WrapPc)) dutWrap (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req        (wReq),
        .imem_addr       (wAddr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .instr           (wInstr),
        .instr_valid     (wValid),
        .pc              (wPc),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .align_err       (wAlign),
        .issue_count     (wCount)
    );

    always #5 clk = ~clk;

    int errCount = 0;
    int checkCount = 0;

    // Reference state
    logic [31:0] expPc = ResetPc;
    logic [31:0] lastInstr = 32'h0;
    logic [15:0] expCount = 16'h0;
    logic        expAlign = 1'b0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One transaction: called at a negedge while the DUT should be in FETCH.
    // w wait cycles before ack, s stall cycles before issue. Returns at the
    // negedge after the issue edge.
    task automatic fetchIssue(input int w, input int s, input logic redir,
                              input logic [31:0] tgt, input logic [31:0] data);
        for (int i = 0; i <= w; i++) begin
            checkVal("fetchReq",   {31'd0, imem_req}, 32'd1);
            checkVal("fetchAddr",  imem_addr, expPc);
            checkVal("fetchPc",    pc, expPc);
            checkVal("fetchValid", {31'd0, instr_valid}, 32'd0);
            checkVal("fetchInstr", instr, lastInstr);
            checkVal("fetchCount", {16'd0, issue_count}, {16'd0, expCount});
            imem_ack        = (i == w);
            imem_rdata      = (i == w) ? data : $urandom;
            stall           = 1'($urandom_range(0, 1));
            redirect        = 1'($urandom_range(0, 1));
            redirect_target = $urandom;
            @(negedge clk);
        end
        for (int j = 0; j <= s; j++) begin
            checkVal("issueReq",   {31'd0, imem_req}, 32'd0);
            checkVal("issueValid", {31'd0, instr_valid}, 32'd1);
            checkVal("issueInstr", instr, data);
            checkVal("issuePc",    pc, expPc);
            checkVal("issueCount", {16'd0, issue_count}, {16'd0, expCount});
            checkVal("issueAlign", {31'd0, align_err}, {31'd0, expAlign});
            imem_ack   = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
            if (j < s) begin
                stall           = 1'b1;
                redirect        = 1'b1;
                redirect_target = $urandom;
            end else begin
                stall           = 1'b0;
                redirect        = redir;
                redirect_target = tgt;
            end
            @(negedge clk);
        end
        lastInstr = data;
        if (expCount != 16'hFFFF) expCount = expCount + 16'd1;
        if (redir) begin
            expPc = {tgt[31:2], 2'b00};
            if (tgt[1:0] != 2'b00) expAlign = 1'b1;
        end else begin
            expPc = expPc + 32'd4;
        end
        imem_ack = 1'b0;
        redirect = 1'b0;
        stall    = 1'b0;
    endtask

    initial begin
        // Reset values
        rst_n = 1'b0;
        #1;
        checkVal("rstReq",   {31'd0, imem_req}, 32'd0);
        checkVal("rstAddr",  imem_addr, ResetPc);
        checkVal("rstPc",    pc, ResetPc);
        checkVal("rstInstr", instr, 32'd0);
        checkVal("rstValid", {31'd0, instr_valid}, 32'd0);
        checkVal("rstAlign", {31'd0, align_err}, 32'd0);
        checkVal("rstCount", {16'd0, issue_count}, 32'd0);
        checkVal("rstWrap",  {wInstr[30:0], wValid} | {31'd0, wAlign} | {16'd0, wCount}, 32'd0);
        checkVal("rstWrapPc", wPc, WrapPc);

        // Release before edge 0: one IDLE cycle with no request
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkVal("idleReq",  {31'd0, imem_req}, 32'd0);
        checkVal("idleAddr", imem_addr, ResetPc);
        @(negedge clk);
        checkVal("wrapAddr0", wAddr, WrapPc);

        // Five zero-wait, no-stall instructions
        for (int k = 0; k < 5; k++) begin
            fetchIssue(0, 0, 1'b0, 32'h0, $urandom);
            if (k == 0) begin
                checkVal("wrapReq",   {31'd0, wReq}, 32'd1);
                checkVal("wrapAddr1", wAddr, 32'h0000_0000);
            end
        end
        checkVal("count5", {16'd0, issue_count}, 32'd5);
        checkVal("pc5",    imem_addr, 32'h0040_0014);

        // Three wait states then four stall cycles
        fetchIssue(3, 4, 1'b0, 32'h0, 32'hA5A5_1234);
        checkVal("countWaitStall", {16'd0, issue_count}, 32'd6);

        // Redirects: aligned, misaligned, and redirect held only during stall
        fetchIssue(0, 0, 1'b1, 32'h0000_0100, $urandom);
        checkVal("redirAddr",   imem_addr, 32'h0000_0100);
        checkVal("redirAlign0", {31'd0, align_err}, 32'd0);
        fetchIssue(1, 0, 1'b1, 32'h0000_0202, $urandom);
        checkVal("misAddr",   imem_addr, 32'h0000_0200);
        checkVal("misAlign1", {31'd0, align_err}, 32'd1);
        fetchIssue(0, 3, 1'b0, 32'h0, $urandom);
        checkVal("stallRedirIgnored", imem_addr, 32'h0000_0204);
        checkVal("alignSticky", {31'd0, align_err}, 32'd1);

        // Randomized transactions
        for (int k = 0; k < 150; k++) begin
            fetchIssue($urandom_range(0, 3), $urandom_range(0, 3),
                       ($urandom_range(0, 3) == 0), $urandom, $urandom);
        end

        // Saturation: preload the counter close to the top via its next-state
        // value while the DUT waits in FETCH, then issue past the limit.
        force dut.issueCountD = 16'hFFFC;
        @(posedge clk);
        #1;
        release dut.issueCountD;
        expCount = 16'hFFFC;
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            fetchIssue($urandom_range(0, 1), $urandom_range(0, 1), 1'b0, 32'h0, $urandom);
        end
        checkVal("countSat", {16'd0, issue_count}, 32'h0000_FFFF);

        // Reset mid-fetch with ack pending
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #2;
        rst_n = 1'b0;
        #1;
        checkVal("midRstReq",   {31'd0, imem_req}, 32'd0);
        checkVal("midRstPc",    pc, ResetPc);
        checkVal("midRstValid", {31'd0, instr_valid}, 32'd0);
        checkVal("midRstCount", {16'd0, issue_count}, 32'd0);
        checkVal("midRstAlign", {31'd0, align_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkVal("strayAckValid", {31'd0, instr_valid}, 32'd0);
        checkVal("strayAckInstr", instr, 32'd0);
        checkVal("strayAckReq",   {31'd0, imem_req}, 32'd1);
        imem_ack = 1'b0;

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
